// File: rtl/pe_array_pkg.sv
// Shared constants, operand/accumulator types and the MAC update rule for the 8x8 systolic array.
// Defining PE_ACC_SATURATE_EN makes the accumulator clamp at its signed limits instead of wrapping.
package pe_array_pkg;

    localparam int DIM = 8;
    localparam int DW  = 16;
    localparam int AW  = 36;

    typedef logic signed [DW-1:0] operand_t;
    typedef logic signed [AW-1:0] acc_t;

    function automatic acc_t mac_next(input acc_t acc, input operand_t a, input operand_t w);
        logic signed [2*DW-1:0] prod;
`ifdef PE_ACC_SATURATE_EN
        logic signed [AW:0] wide;
`endif
        prod = a * w;
`ifdef PE_ACC_SATURATE_EN
        // One extra bit exposes overflow: top two bits differ only when the sum left the AW-bit range.
        wide = {acc[AW-1], acc} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
        if (wide[AW] != wide[AW-1]) begin
            mac_next = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            mac_next = wide[AW-1:0];
        end
`else
        mac_next = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
`endif
    endfunction

endpackage

// File: rtl/pe_mac_cell.sv
// One output-stationary PE: registers the passing activation, weight and done flag,
// and accumulates a*w until the first done flag arrives, after which acc is frozen.
module pe_mac_cell
    import pe_array_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  operand_t a_in,
    input  operand_t w_in,
    input  logic     d_in,
    output operand_t a_out,
    output operand_t w_out,
    output logic     d_out,
    output acc_t     acc
);

    operand_t a_q, a_d;
    operand_t w_q, w_d;
    logic     d_q, d_d;
    acc_t     acc_q, acc_d;
    logic     sticky_q, sticky_d;

    always_comb begin
        a_d      = a_q;
        w_d      = w_q;
        d_d      = d_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        if (en) begin
            a_d = a_in;
            w_d = w_in;
            d_d = d_in;
            // The edge that carries done does not accumulate its operands.
            if (d_in) begin
                sticky_d = 1'b1;
            end else if (!sticky_q) begin
                acc_d = mac_next(acc_q, a_in, w_in);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            w_q      <= '0;
            d_q      <= 1'b0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            w_q      <= w_d;
            d_q      <= d_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end

    assign a_out = a_q;
    assign w_out = w_q;
    assign d_out = d_q;
    assign acc   = acc_q;

endmodule

// File: rtl/pe_8x8_systolic_array.sv
// 8x8 output-stationary MAC grid: activations/done ripple east, weights ripple south,
// all accumulators exposed flat. Optional PE_ACC_SATURATE_EN selects saturating accumulation.
module pe_8x8_systolic_array
    import pe_array_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [DIM*DW-1:0]      activations,
    input  logic [DIM*DW-1:0]      weights,
    input  logic [DIM-1:0]         done,
    output logic [DIM-1:0]         output_dones,
    output logic [DIM*DW-1:0]      o_activations,
    output logic [DIM*DW-1:0]      o_weights,
    output logic [DIM*DIM*AW-1:0]  results
);

    // Column index DIM of the east grids and row index DIM of the south grid are the array edges.
    operand_t a_grid [DIM][DIM+1];
    logic     d_grid [DIM][DIM+1];
    operand_t w_grid [DIM+1][DIM];
    acc_t     acc_grid [DIM][DIM];

    for (genvar i = 0; i < DIM; i++) begin : g_edge
        assign a_grid[i][0]                = activations[DW*i +: DW];
        assign d_grid[i][0]                = done[i];
        assign w_grid[0][i]                = weights[DW*i +: DW];
        assign o_activations[DW*i +: DW]   = a_grid[i][DIM];
        assign output_dones[i]             = d_grid[i][DIM];
        assign o_weights[DW*i +: DW]       = w_grid[DIM][i];
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            pe_mac_cell u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .a_in  (a_grid[r][c]),
                .w_in  (w_grid[r][c]),
                .d_in  (d_grid[r][c]),
                .a_out (a_grid[r][c+1]),
                .w_out (w_grid[r+1][c]),
                .d_out (d_grid[r][c+1]),
                .acc   (acc_grid[r][c])
            );
            assign results[AW*(DIM*r+c) +: AW] = acc_grid[r][c];
        end
    end

endmodule

// File: tb/tb_pe_8x8_systolic_array.sv
// Randomized bench for pe_8x8_systolic_array: a delay-line reference model predicts every output
// after each clock edge into a queue; a monitor pops and compares after each rising edge.
module tb_pe_8x8_systolic_array;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [127:0]   activations;
  logic [127:0]   weights;
  logic [7:0]     done;
  logic [7:0]     output_dones;
  logic [127:0]   o_activations;
  logic [127:0]   o_weights;
  logic [2303:0]  results;

  always #5 clk = ~clk;

  pe_8x8_systolic_array dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .activations(activations), .weights(weights), .done(done),
    .output_dones(output_dones), .o_activations(o_activations),
    .o_weights(o_weights), .results(results)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [2303:0] exp_res_q[$];
  logic [127:0]  exp_oa_q[$];
  logic [127:0]  exp_ow_q[$];
  logic [7:0]    exp_od_q[$];

  // Reference: hist[j] holds the edge input applied j enabled edges ago.
  longint        m_acc [N][N];
  bit            m_st  [N][N];
  logic [15:0]   ah [N][N];   // [delay][row]
  logic [15:0]   wh [N][N];   // [delay][col]
  bit            dh [N][N];   // [delay][row]

  function automatic longint ref_add(input longint acc, input longint prod);
    longint s;
    s = acc + prod;
`ifdef PE_ACC_SATURATE_EN
    if (s > 64'sd34359738367) s = 64'sd34359738367;
    if (s < -64'sd34359738368) s = -64'sd34359738368;
`else
    s = s & 64'h0000_000F_FFFF_FFFF;
    if (s >= 64'sd34359738368) s = s - 64'sd68719476736;
`endif
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_acc[r][c] = 0; m_st[r][c] = 0;
        ah[r][c] = '0; wh[r][c] = '0; dh[r][c] = 0;
      end
  endtask

  task automatic model_edge();
    logic [2303:0] er;
    logic [127:0]  eoa, eow;
    logic [7:0]    eod;
    if (!rst_n) begin
      model_clear();
    end else if (en) begin
      for (int j = N-1; j > 0; j--)
        for (int i = 0; i < N; i++) begin
          ah[j][i] = ah[j-1][i]; wh[j][i] = wh[j-1][i]; dh[j][i] = dh[j-1][i];
        end
      for (int i = 0; i < N; i++) begin
        ah[0][i] = activations[16*i +: 16];
        wh[0][i] = weights[16*i +: 16];
        dh[0][i] = done[i];
      end
      // PE(r,c) sees row r's input from c edges ago and column c's input from r edges ago.
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          if (dh[c][r]) m_st[r][c] = 1;
          else if (!m_st[r][c])
            m_acc[r][c] = ref_add(m_acc[r][c],
                                  longint'($signed(ah[c][r])) * longint'($signed(wh[r][c])));
        end
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) er[36*(8*r+c) +: 36] = 36'(m_acc[r][c]);
    for (int i = 0; i < N; i++) begin
      eoa[16*i +: 16] = ah[N-1][i];
      eow[16*i +: 16] = wh[N-1][i];
      eod[i]          = dh[N-1][i];
    end
    exp_res_q.push_back(er);
    exp_oa_q.push_back(eoa);
    exp_ow_q.push_back(eow);
    exp_od_q.push_back(eod);
  endtask

  always @(posedge clk) begin
    logic [2303:0] er;
    logic [127:0]  eoa, eow;
    logic [7:0]    eod;
    #2;
    if (exp_res_q.size() > 0) begin
      er = exp_res_q.pop_front();
      eoa = exp_oa_q.pop_front();
      eow = exp_ow_q.pop_front();
      eod = exp_od_q.pop_front();
      tests_run += 4;
      if (results !== er) begin
        tests_failed++;
        for (int k = 0; k < 64; k++)
          if (results[36*k +: 36] !== er[36*k +: 36]) begin
            $display("[TB] FAIL results PE(%0d,%0d) at %0t: got %h expected %h",
                     k / 8, k % 8, $time, results[36*k +: 36], er[36*k +: 36]);
            break;
          end
      end
      if (o_activations !== eoa) begin
        tests_failed++;
        $display("[TB] FAIL o_activations at %0t: got %h expected %h", $time, o_activations, eoa);
      end
      if (o_weights !== eow) begin
        tests_failed++;
        $display("[TB] FAIL o_weights at %0t: got %h expected %h", $time, o_weights, eow);
      end
      if (output_dones !== eod) begin
        tests_failed++;
        $display("[TB] FAIL output_dones at %0t: got %h expected %h", $time, output_dones, eod);
      end
    end
  end

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_results"}, 64'(|results), 64'd0);
    check_val({tag, "_o_act"},   64'(|o_activations), 64'd0);
    check_val({tag, "_o_wts"},   64'(|o_weights), 64'd0);
    check_val({tag, "_o_dones"}, 64'(output_dones), 64'd0);
  endtask

  task automatic step(input logic [127:0] a, input logic [127:0] w, input logic [7:0] d,
                      input logic e, input logic r);
    @(negedge clk);
    activations = a; weights = w; done = d; en = e; rst_n = r;
    model_edge();
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    step('0, '0, '0, 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [127:0] rand128();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Skewed 4-term dot product: row r / column c delayed r / c edges, garbage after each stream.
  task automatic run_dot(input int hold_at);
    logic [15:0]  A [N][4];
    logic [15:0]  B [4][N];
    logic [127:0] a, w;
    logic [7:0]   d;
    longint       s;
    logic [63:0]  sv;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        A[i][k] = 16'($urandom);
        B[k][i] = 16'($urandom);
      end
    for (int t = 0; t < 28; t++) begin
      if (t == hold_at)
        for (int h = 0; h < 5; h++) step(rand128(), rand128(), 8'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < N; i++) begin
        if (t >= i && t - i < 4) begin
          a[16*i +: 16] = A[i][t-i];
          w[16*i +: 16] = B[t-i][i];
        end else if (t - i >= 4) begin
          a[16*i +: 16] = 16'($urandom);
          w[16*i +: 16] = 16'($urandom);
        end else begin
          a[16*i +: 16] = '0;
          w[16*i +: 16] = '0;
        end
        d[i] = (t - i >= 4);
      end
      step(a, w, d, 1'b1, 1'b1);
    end
    settle();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += longint'($signed(A[r][k])) * longint'($signed(B[k][c]));
        sv = s;
        check_val($sformatf("dot_pe_%0d_%0d", r, c), 64'(results[36*(8*r+c) +: 36]), 64'(sv[35:0]));
      end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; activations = '0; weights = '0; done = '0;
    model_clear();
    #1;
    check_all_zero("reset");

    // Idle after reset
    for (int i = 0; i < 20; i++) step('0, '0, '0, 1'b1, 1'b1);
    settle();
    check_all_zero("idle");

    // Single MAC
    step(128'd3, 128'd5, '0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step('0, '0, '0, 1'b1, 1'b1);
    settle();
    check_val("single_mac_pe00", 64'(results[35:0]), 64'd15);
    check_val("single_mac_pe01", 64'(results[71:36]), 64'd0);
    check_val("single_mac_pe10", 64'(results[36*8 +: 36]), 64'd0);

    // Signed product
    do_reset();
    step(128'h0000_FFFE, 128'd7, '0, 1'b1, 1'b1);
    step('0, '0, '0, 1'b1, 1'b1);
    settle();
    check_val("signed_mac_pe00", 64'(results[35:0]), 64'h0000_000F_FFFF_FFF2);

    // Skewed dot products, then the same with an enable hold mid-stream
    do_reset();
    run_dot(-1);
    do_reset();
    run_dot(6);

    // Async reset between edges mid-stream, then a clean restart without a synchronous reset
    do_reset();
    for (int i = 0; i < 10; i++) step(rand128(), rand128(), '0, 1'b1, 1'b1);
    settle();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_clear();
    rst_n = 1'b1;
    run_dot(-1);

    // Random traffic with random enable and sparse done flags
    do_reset();
    for (int i = 0; i < 150; i++)
      step(rand128(), rand128(),
           8'(($urandom_range(0, 9) == 0) ? $urandom : 0),
           1'($urandom_range(0, 4) != 0), 1'b1);
    settle();
    settle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
